fmul_seq: RTL and testbench
===========================

// Module: fmul_seq
// PURPOSE
//   Sequencer for the single-precision multiplier datapath. Accepts {a, b, rm, tag} requests on a
//   valid/ready port and buffers them in a DEPTH-entry FIFO. Issues one request at a time to the
//   fmul datapath through registered operand outputs, then waits LAT cycles and captures the product.
//   Presents the result, tag and class flags on a valid/ready output port to the writeback stage.
// PARAMETERS
//   DEPTH  4  request FIFO entries; power of two, 2..16
//   LAT    1  cycles from operand register update to fm_s being stable; 1..15
//   TAG_W  5  width of request tag (destination register index)
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rst        in   1      reset; synchronous and active-high
//   in_valid   in   1      request present
//   in_ready   out  1      FIFO can accept (count != DEPTH)
//   in_a       in   32     operand a, IEEE-754 single
//   in_b       in   32     operand b, IEEE-754 single
//   in_rm      in   2      rounding mode 00 RNE, 01 RDN, 10 RUP, 11 RTZ
//   in_tag     in   TAG_W  request tag
//   fm_a       out  32     registered operand a to fmul
//   fm_b       out  32     registered operand b to fmul
//   fm_rm      out  2      registered rounding mode to fmul
//   fm_s       in   32     product from fmul
//   out_valid  out  1      result held for writeback
//   out_ready  in   1      writeback accepts result
//   out_s      out  32     captured product
//   out_tag    out  TAG_W  tag of captured product
//   out_flags  out  4      {nan, inf, zero, denorm} class of out_s
//   busy       out  1      FIFO non-empty or FSM not IDLE
//   done_cnt   out  16     completed (handed-off) operations; wraps 0xFFFF->0
// BEHAVIOUR
//   - Reset values: in_ready=1, out_valid=0, busy=0, done_cnt=0; fm_a/fm_b/out_s/out_tag/out_flags=0, fm_rm=00.
//     FIFO pointers and count=0. FSM=IDLE. Reset mid-operation discards all queued and in-flight work.
//   - FIFO: a push occurs on in_valid&in_ready. in_ready depends only on the registered count, not on a
//     same-cycle pop, so a full FIFO refuses input even while popping. Pointers wrap modulo DEPTH.
//     Simultaneous push and pop leaves count unchanged. A pushed entry becomes poppable the next cycle.
//   - FSM IDLE: if count!=0, pop head into fm_a/fm_b/fm_rm and an internal tag register,
//     load cnt=LAT-1, and go to EXEC.
//   - FSM EXEC: while cnt!=0, decrement cnt. When cnt==0, capture fm_s into out_s, the tag into out_tag,
//     and the class into out_flags, then go to DONE (out_valid=1 from the next cycle).
//   - FSM DONE: out_valid=1, outputs stable. On out_ready, increment done_cnt. Then, if count!=0,
//     pop and go to EXEC (back-to-back, no IDLE bubble); else go to IDLE. out_valid drops the cycle after
//     a handshake unless a new capture occurs.
//   - Latency: request pushed at edge T -> out_valid first high after edge T+LAT+1 (FIFO was empty,
//     FSM IDLE). Steady throughput: one result per LAT+1 cycles with out_ready held high.
//   - fm_a/fm_b/fm_rm change only on a pop; they are held through EXEC and DONE.
//   - Class, from exponent e=s[30:23] and fraction f=s[22:0]:
//     nan = e==FF & f!=0; inf = e==FF & f==0; zero = e==00 & f==0; denorm = e==00 & f!=0.
//   - Results are in-order; tags pass through unmodified. No flush other than rst.
// TESTING
//   - Single op: a=3FC00000, b=40000000, rm=00, tag=3; LAT=1 -> out_s=40400000, out_tag=3, flags=0000,
//     out_valid at T+2.
//   - Invalid: a=7F800000, b=00000000 -> out_s=7FC00000, flags=1000.
//   - Overflow by mode: a=b=7F000000 with rm=00 -> 7F800000 (flags 0100); rm=11 -> 7F7FFFFF (flags 0000).
//   - Backpressure: push 5 ops with out_ready=0, DEPTH=4 -> in_ready low after 4 pushes into FIFO plus
//     1 in flight. Release out_ready -> all results in order, tags match, done_cnt=5.
//   - Underflow/zero: a=b=00800000 rm=00 -> out_s=00000000 flags 0010; a=3F000000, b=00800000 -> 00400000 flags 0001.
//   - Reset during EXEC with 2 queued -> next cycle out_valid=0, busy=0, in_ready=1, done_cnt=0,
//     and no stale result ever appears.

Source files
------------

// File: rtl/fmul_seq_if.sv
// Request, fmul-operand and writeback signals of the multiplier sequencer.
interface fmul_seq_if #(
  parameter int unsigned TAG_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_a;
  logic [31:0]       in_b;
  logic [1:0]        in_rm;
  logic [TAG_W-1:0]  in_tag;
  logic [31:0]       fm_a;
  logic [31:0]       fm_b;
  logic [1:0]        fm_rm;
  logic [31:0]       fm_s;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_s;
  logic [TAG_W-1:0]  out_tag;
  logic [3:0]        out_flags;
  logic              busy;
  logic [15:0]       done_cnt;

  // Sequencer side
  modport slave (
    input  in_valid, in_a, in_b, in_rm, in_tag, fm_s, out_ready,
    output in_ready, fm_a, fm_b, fm_rm, out_valid, out_s, out_tag, out_flags, busy, done_cnt
  );

  // Requester / datapath / writeback side
  modport master (
    output in_valid, in_a, in_b, in_rm, in_tag, fm_s, out_ready,
    input  in_ready, fm_a, fm_b, fm_rm, out_valid, out_s, out_tag, out_flags, busy, done_cnt
  );
endinterface

// File: rtl/fmul_seq.sv
// Sequencer for the single-precision multiplier: request FIFO, operand issue,
// LAT-cycle wait, product capture and writeback handshake.
module fmul_seq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 1,
  parameter int unsigned TAG_W = 5
) (
  input  logic      clk,
  input  logic      rst,
  fmul_seq_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LCT_W = 4;
  localparam int unsigned ENT_W = 32 + 32 + 2 + TAG_W;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state, state_nx;
  logic [LCT_W-1:0]   lcnt, lcnt_nx;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_nx;
  logic [TAG_W-1:0]   tag_q;
  logic               push_c, pop_c, capture_c, hand_c;
  logic [ENT_W-1:0]   head_c;

  // IEEE-754 class of a product: {nan, inf, zero, denorm}
  function automatic logic [3:0] classify(input logic [31:0] s);
    logic e_ones, e_zero, f_zero;
    e_ones = (s[30:23] == 8'hFF);
    e_zero = (s[30:23] == 8'h00);
    f_zero = (s[22:0] == 23'd0);
    return {e_ones & ~f_zero, e_ones & f_zero, e_zero & f_zero, e_zero & ~f_zero};
  endfunction

  assign push_c   = bus.in_valid & bus.in_ready;
  assign head_c   = mem[rd_ptr];
  assign count_nx = count + CNT_W'(push_c) - CNT_W'(pop_c);

  // Next-state and control strobes; DONE can pop straight back into EXEC
  always_comb begin
    state_nx  = state;
    lcnt_nx   = lcnt;
    pop_c     = 1'b0;
    capture_c = 1'b0;
    hand_c    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop_c    = 1'b1;
          lcnt_nx  = LCT_W'(LAT - 1);
          state_nx = EXEC;
        end
      end
      EXEC: begin
        if (lcnt != '0) begin
          lcnt_nx = lcnt - LCT_W'(1);
        end else begin
          capture_c = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          hand_c = 1'b1;
          if (count != '0) begin
            pop_c    = 1'b1;
            lcnt_nx  = LCT_W'(LAT - 1);
            state_nx = EXEC;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM, FIFO pointers and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lcnt         <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.in_ready <= 1'b1;
      bus.busy     <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.done_cnt <= '0;
    end else begin
      state <= state_nx;
      lcnt  <= lcnt_nx;
      count <= count_nx;
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      bus.in_ready  <= (count_nx != CNT_W'(DEPTH));
      bus.busy      <= (count_nx != '0) || (state_nx != IDLE);
      bus.out_valid <= (state_nx == DONE);
      if (hand_c) bus.done_cnt <= bus.done_cnt + 16'd1;
    end
  end

  // FIFO storage; contents are don't-care until pointed at by a valid count
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= {bus.in_a, bus.in_b, bus.in_rm, bus.in_tag};
  end

  // Operand issue on pop and product capture at the end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fm_a      <= '0;
      bus.fm_b      <= '0;
      bus.fm_rm     <= '0;
      tag_q         <= '0;
      bus.out_s     <= '0;
      bus.out_tag   <= '0;
      bus.out_flags <= '0;
    end else begin
      if (pop_c) begin
        bus.fm_a  <= head_c[ENT_W-1 -: 32];
        bus.fm_b  <= head_c[ENT_W-33 -: 32];
        bus.fm_rm <= head_c[TAG_W+1 -: 2];
        tag_q     <= head_c[TAG_W-1:0];
      end
      if (capture_c) begin
        bus.out_s     <= bus.fm_s;
        bus.out_tag   <= tag_q;
        bus.out_flags <= classify(bus.fm_s);
      end
    end
  end

endmodule

// File: tb/tb_fmul_seq.sv
// Directed bench for fmul_seq with a table-driven fmul stand-in and a result scoreboard.
module tb_fmul_seq;

  localparam int unsigned TAG_W = 5;

  typedef struct packed {
    logic [31:0]      s;
    logic [TAG_W-1:0] tag;
    logic [3:0]       flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   exp_done = 0;
  exp_t sb [$];

  fmul_seq_if #(.TAG_W(TAG_W)) bus ();

  fmul_seq #(.DEPTH(4), .LAT(1), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Known products for the directed vectors; anything else gets a scrambled stand-in
  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] rm);
    case ({a, b, rm})
      {32'h3FC00000, 32'h40000000, 2'b00}: return 32'h40400000;
      {32'h7F800000, 32'h00000000, 2'b00}: return 32'h7FC00000;
      {32'h7F000000, 32'h7F000000, 2'b00}: return 32'h7F800000;
      {32'h7F000000, 32'h7F000000, 2'b11}: return 32'h7F7FFFFF;
      {32'h00800000, 32'h00800000, 2'b00}: return 32'h00000000;
      {32'h3F000000, 32'h00800000, 2'b00}: return 32'h00400000;
      default: return a ^ {b[15:0], b[31:16]} ^ {30'd0, rm};
    endcase
  endfunction

  function automatic logic [3:0] cls(input logic [31:0] s);
    logic [7:0]  e;
    logic [22:0] f;
    e = s[30:23];
    f = s[22:0];
    return {(e == 8'hFF) && (f != 0), (e == 8'hFF) && (f == 0),
            (e == 8'h00) && (f == 0), (e == 8'h00) && (f != 0)};
  endfunction

  assign bus.fm_s = fmul_model(bus.fm_a, bus.fm_b, bus.fm_rm);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request (entered at a negedge), record its expected result once accepted
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                      input logic [TAG_W-1:0] tag, input logic [31:0] es, input logic [3:0] ef);
    int n;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_rm = rm;
    bus.in_tag = tag;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("push_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      e.s = es;
      e.tag = tag;
      e.flags = ef;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic push_rand(input logic [TAG_W-1:0] tag);
    logic [31:0] a, b, s;
    logic [1:0]  rm;
    a = $urandom;
    b = $urandom;
    rm = 2'($urandom_range(0, 3));
    s = fmul_model(a, b, rm);
    push(a, b, rm, tag, s, cls(s));
  endtask

  // Accept one result and compare it with the scoreboard head
  task automatic collect(input string name);
    int   n;
    exp_t e;
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      chk({name, "_timeout"}, 32'(bus.out_valid), 32'd1);
    end else if (sb.size() == 0) begin
      chk({name, "_unexpected"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({name, "_s"}, bus.out_s, e.s);
      chk({name, "_tag"}, 32'(bus.out_tag), 32'(e.tag));
      chk({name, "_flags"}, 32'(bus.out_flags), 32'(e.flags));
      exp_done++;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_done = 0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_rm = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset values while reset is held
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done_cnt", 32'(bus.done_cnt), 32'd0);
    chk("rst_fm_a", bus.fm_a, 32'd0);
    chk("rst_fm_rm", 32'(bus.fm_rm), 32'd0);
    chk("rst_out_s", bus.out_s, 32'd0);
    chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single op: latency T+2 and operand hold
    push(32'h3FC00000, 32'h40000000, 2'b00, 5'd3, 32'h40400000, 4'b0000);
    chk("lat_t0", 32'(bus.out_valid), 32'd0);
    chk("lat_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("lat_t1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_t2", 32'(bus.out_valid), 32'd1);
    chk("hold_fm_a", bus.fm_a, 32'h3FC00000);
    chk("hold_fm_b", bus.fm_b, 32'h40000000);
    collect("single");
    chk("single_done_cnt", 32'(bus.done_cnt), 32'(exp_done));
    chk("single_idle_valid", 32'(bus.out_valid), 32'd0);

    // Invalid operation
    push(32'h7F800000, 32'h00000000, 2'b00, 5'd7, 32'h7FC00000, 4'b1000);
    collect("invalid");

    // Overflow under two rounding modes, queued together
    push(32'h7F000000, 32'h7F000000, 2'b00, 5'd8, 32'h7F800000, 4'b0100);
    push(32'h7F000000, 32'h7F000000, 2'b11, 5'd9, 32'h7F7FFFFF, 4'b0000);
    collect("ovf_rne");
    collect("ovf_rtz");

    // Underflow to zero and to denormal
    push(32'h00800000, 32'h00800000, 2'b00, 5'd1, 32'h00000000, 4'b0010);
    push(32'h3F000000, 32'h00800000, 2'b00, 5'd2, 32'h00400000, 4'b0001);
    collect("unf_zero");
    collect("unf_denorm");
    chk("seq_done_cnt", 32'(bus.done_cnt), 32'(exp_done));

    // Backpressure: four in the FIFO plus one held in DONE
    reset_dut();
    for (int i = 0; i < 5; i++) push_rand(5'(10 + i));
    chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_hold", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 5; i++) collect($sformatf("bp%0d", i));
    chk("bp_done_cnt", 32'(bus.done_cnt), 32'd5);
    chk("bp_drained_busy", 32'(bus.busy), 32'd0);
    chk("bp_drained_ready", 32'(bus.in_ready), 32'd1);

    // Reset while the second op executes with two still queued
    reset_dut();
    for (int i = 0; i < 4; i++) push_rand(5'(20 + i));
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("mid_exec_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_exec_done_cnt", 32'(bus.done_cnt), 32'd1);
    rst = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_done = 0;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst_done_cnt", 32'(bus.done_cnt), 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("mrst_stale%0d", i), 32'(bus.out_valid), 32'd0);
    end
    bus.out_ready = 1'b0;

    // Clean operation after the mid-flight reset
    push(32'h3FC00000, 32'h40000000, 2'b00, 5'd31, 32'h40400000, 4'b0000);
    collect("post_rst");
    chk("post_rst_done_cnt", 32'(bus.done_cnt), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
